// File: rtl/miner_job_sched.sv
// miner_job_sched: two-deep job buffer in front of one sha_top mining core.
// It starts the core on the active job, runs a watchdog on each job, and
// returns one tagged result per job. A queued job restarts the core right
// after the previous result is drained.
module miner_job_sched #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4_000_000_000,
  parameter int unsigned JOB_ID_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [255:0]        job_prev_h,
  input  logic [95:0]         job_msg,
  input  logic [255:0]        job_prev_blk,
  input  logic                abort,
  output logic                core_en,
  output logic                core_abort,
  output logic [255:0]        core_prev_h,
  output logic [95:0]         core_msg,
  output logic [255:0]        core_prev_blk,
  input  logic                core_done,
  input  logic                core_found,
  input  logic [31:0]         core_nonce,
  input  logic [255:0]        core_hash,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [JOB_ID_W-1:0] res_id,
  output logic [1:0]          res_status,
  output logic [31:0]         res_nonce,
  output logic [255:0]        res_hash,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_REPORT = 2'd2} state_t;

  localparam logic [1:0] ST_EXHAUSTED = 2'b00;
  localparam logic [1:0] ST_FOUND     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;
  // Watchdog is registered, so the firing edge is the one where it would
  // step from TIMEOUT_CYCLES-2 up to TIMEOUT_CYCLES-1.
  localparam logic [31:0] WDOG_FIRE   = TIMEOUT_CYCLES - 32'd2;

  state_t              state_r, state_nx_s;
  logic                act_v_r, pend_v_r;
  logic [JOB_ID_W-1:0] act_id_r, pend_id_r, next_id_r;
  logic [255:0]        act_prev_h_r, pend_prev_h_r;
  logic [95:0]         act_msg_r, pend_msg_r;
  logic [255:0]        act_prev_blk_r, pend_prev_blk_r;
  logic [31:0]         wdog_r;
  logic                core_en_r, core_abort_r;
  logic                res_valid_r;
  logic [JOB_ID_W-1:0] res_id_r;
  logic [1:0]          res_status_r;
  logic [31:0]         res_nonce_r;
  logic [255:0]        res_hash_r;
  logic                accept_s, start_s, cap_done_s, cap_to_s, release_s;

  assign job_ready     = !abort && !pend_v_r;
  assign accept_s      = job_valid && job_ready;
  assign busy          = act_v_r || pend_v_r || res_valid_r;
  assign core_en       = core_en_r;
  assign core_abort    = core_abort_r;
  assign core_prev_h   = act_prev_h_r;
  assign core_msg      = act_msg_r;
  assign core_prev_blk = act_prev_blk_r;
  assign res_valid     = res_valid_r;
  assign res_id        = res_id_r;
  assign res_status    = res_status_r;
  assign res_nonce     = res_nonce_r;
  assign res_hash      = res_hash_r;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and per-edge control strobes; abort overrides everything.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    cap_done_s = 1'b0;
    cap_to_s   = 1'b0;
    release_s  = 1'b0;
    if (abort) begin
      state_nx_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (act_v_r) begin
            state_nx_s = S_RUN;
            start_s    = 1'b1;
          end else begin
            state_nx_s = S_IDLE;
          end
        end
        S_RUN: begin
          if (core_done) begin
            cap_done_s = 1'b1;
            state_nx_s = S_REPORT;
          end else if (wdog_r == WDOG_FIRE) begin
            cap_to_s   = 1'b1;
            state_nx_s = S_REPORT;
          end else begin
            state_nx_s = S_RUN;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            release_s  = 1'b1;
            state_nx_s = S_IDLE;
          end else begin
            state_nx_s = S_REPORT;
          end
        end
        default: begin
          state_nx_s = S_IDLE;
        end
      endcase
    end
  end

  // Active/pending slots and the job tag counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_v_r         <= 1'b0;
      pend_v_r        <= 1'b0;
      act_id_r        <= '0;
      pend_id_r       <= '0;
      next_id_r       <= '0;
      act_prev_h_r    <= 256'd0;
      act_msg_r       <= 96'd0;
      act_prev_blk_r  <= 256'd0;
      pend_prev_h_r   <= 256'd0;
      pend_msg_r      <= 96'd0;
      pend_prev_blk_r <= 256'd0;
    end else if (abort) begin
      act_v_r  <= 1'b0;
      pend_v_r <= 1'b0;
    end else begin
      if (accept_s) begin
        next_id_r <= next_id_r + JOB_ID_W'(1);
      end
      if (release_s && pend_v_r) begin
        // job_ready is low while pending is full, so no accept can collide here
        act_prev_h_r   <= pend_prev_h_r;
        act_msg_r      <= pend_msg_r;
        act_prev_blk_r <= pend_prev_blk_r;
        act_id_r       <= pend_id_r;
        pend_v_r       <= 1'b0;
      end else if (accept_s && (!act_v_r || release_s)) begin
        act_prev_h_r   <= job_prev_h;
        act_msg_r      <= job_msg;
        act_prev_blk_r <= job_prev_blk;
        act_id_r       <= next_id_r;
        act_v_r        <= 1'b1;
      end else if (accept_s) begin
        pend_prev_h_r   <= job_prev_h;
        pend_msg_r      <= job_msg;
        pend_prev_blk_r <= job_prev_blk;
        pend_id_r       <= next_id_r;
        pend_v_r        <= 1'b1;
      end else if (release_s) begin
        act_v_r <= 1'b0;
      end
    end
  end

  // Watchdog plus registered core start/abort pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_r       <= 32'd0;
      core_en_r    <= 1'b0;
      core_abort_r <= 1'b0;
    end else begin
      core_en_r    <= start_s;
      core_abort_r <= (abort && (state_r == S_RUN)) || cap_to_s;
      if (abort || start_s) begin
        wdog_r <= 32'd0;
      end else if (state_r == S_RUN) begin
        wdog_r <= wdog_r + 32'd1;
      end
    end
  end

  // Result capture and hold until the host drains it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid_r  <= 1'b0;
      res_id_r     <= '0;
      res_status_r <= 2'b00;
      res_nonce_r  <= 32'd0;
      res_hash_r   <= 256'd0;
    end else if (abort) begin
      res_valid_r  <= 1'b0;
      res_id_r     <= '0;
      res_status_r <= 2'b00;
      res_nonce_r  <= 32'd0;
      res_hash_r   <= 256'd0;
    end else if (cap_done_s) begin
      res_valid_r  <= 1'b1;
      res_id_r     <= act_id_r;
      res_status_r <= core_found ? ST_FOUND : ST_EXHAUSTED;
      res_nonce_r  <= core_found ? core_nonce : 32'd0;
      res_hash_r   <= core_found ? core_hash : 256'd0;
    end else if (cap_to_s) begin
      res_valid_r  <= 1'b1;
      res_id_r     <= act_id_r;
      res_status_r <= ST_TIMEOUT;
      res_nonce_r  <= 32'd0;
      res_hash_r   <= 256'd0;
    end else if (release_s) begin
      res_valid_r <= 1'b0;
    end
  end

endmodule
